// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/long/repeat events plus a press count.
// Build option: define BTN_REPEAT_EN to enable auto-repeat pulses while the button is held.
module btn_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned TIMER_W       = 32,
    parameter int unsigned COUNT_W       = 8
) (
    input  logic               clockSource,
    input  logic               resetN,
    input  logic               btnState,
    output logic               pressPulse,
    output logic               releasePulse,
    output logic               longPulse,
    output logic               repeatPulse,
    output logic               holdActive,
    output logic [COUNT_W-1:0] pressCount,
    output logic [1:0]         stateDbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 1);

    // Parameter sanity: both intervals need at least two cycles and must fit the timer.
    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : gBadCycles
        $error("btn_event_decoder: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
    end
    if (((LONG_CYCLES - 1) >> TIMER_W) != 0 || ((REPEAT_CYCLES - 1) >> TIMER_W) != 0) begin : gBadWidth
        $error("btn_event_decoder: TIMER_W too narrow for cycle counts");
    end

    state_t             state;
    state_t             stateNext;
    logic               syncMeta;
    logic               s;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timerNext;
    logic               pressNext;
    logic               releaseNext;
    logic               longNext;
    logic               repeatNext;
    logic               holdNext;
    logic [COUNT_W-1:0] countNext;

    assign stateDbg = state;

    always_ff @(posedge clockSource or negedge resetN) begin
        if (!resetN) begin
            syncMeta <= 1'b0;
            s        <= 1'b0;
        end else begin
            syncMeta <= btnState;
            s        <= syncMeta;
        end
    end

    always_comb begin
        stateNext   = state;
        timerNext   = timer;
        pressNext   = 1'b0;
        releaseNext = 1'b0;
        longNext    = 1'b0;
        repeatNext  = 1'b0;
        holdNext    = holdActive;
        countNext   = pressCount;
        case (state)
            IDLE: begin
                if (s) begin
                    pressNext = 1'b1;
                    countNext = pressCount + 1'b1;
                    timerNext = '0;
                    stateNext = PRESSED;
                end
            end
            PRESSED: begin
                // Release wins over the long-press terminal count.
                if (!s) begin
                    releaseNext = 1'b1;
                    stateNext   = IDLE;
                end else if (timer == LONG_LAST) begin
                    longNext  = 1'b1;
                    holdNext  = 1'b1;
                    timerNext = '0;
                    stateNext = HELD;
                end else begin
                    timerNext = timer + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    releaseNext = 1'b1;
                    holdNext    = 1'b0;
                    stateNext   = IDLE;
                end
`ifdef BTN_REPEAT_EN
                else if (timer == TIMER_W'(REPEAT_CYCLES - 1)) begin
                    repeatNext = 1'b1;
                    timerNext  = '0;
                end else begin
                    timerNext = timer + 1'b1;
                end
`endif
            end
            default: begin
                stateNext = IDLE;
                holdNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clockSource or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            timer        <= '0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            longPulse    <= 1'b0;
            repeatPulse  <= 1'b0;
            holdActive   <= 1'b0;
            pressCount   <= '0;
        end else begin
            state        <= stateNext;
            timer        <= timerNext;
            pressPulse   <= pressNext;
            releasePulse <= releaseNext;
            longPulse    <= longNext;
            repeatPulse  <= repeatNext;
            holdActive   <= holdNext;
            pressCount   <= countNext;
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4, COUNT_W=8.
// Repeat expectations follow BTN_REPEAT_EN, matching the DUT build.
module tb_btn_event_decoder;

    localparam int LONG = 8;
    localparam int REP  = 4;
    localparam int CW   = 8;

    logic          clockSource = 1'b0;
    logic          resetN;
    logic          btnState;
    logic          pressPulse;
    logic          releasePulse;
    logic          longPulse;
    logic          repeatPulse;
    logic          holdActive;
    logic [CW-1:0] pressCount;
    logic [1:0]    stateDbg;

    btn_event_decoder #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REP),
        .TIMER_W      (16),
        .COUNT_W      (CW)
    ) dut (
        .clockSource (clockSource),
        .resetN      (resetN),
        .btnState    (btnState),
        .pressPulse  (pressPulse),
        .releasePulse(releasePulse),
        .longPulse   (longPulse),
        .repeatPulse (repeatPulse),
        .holdActive  (holdActive),
        .pressCount  (pressCount),
        .stateDbg    (stateDbg)
    );

    always #5 clockSource = ~clockSource;

    int nChecks = 0;
    int nErrors = 0;
    int cyc;
    int nPress, nRel, nLong, nRep, multiHot;
    int tPress, tRel, tLong, tHoldRise, tHoldFall;
    int tRep[$];
    logic [31:0] exp_q[$];

    task automatic clearMon();
        cyc = 0; nPress = 0; nRel = 0; nLong = 0; nRep = 0; multiHot = 0;
        tPress = -1; tRel = -1; tLong = -1; tHoldRise = -1; tHoldFall = -1;
        tRep.delete();
    endtask

    // Advance n clock edges, sampling outputs 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clockSource);
            cyc++;
            #1;
            if (pressPulse)   begin nPress++; tPress = cyc; end
            if (releasePulse) begin nRel++;   tRel   = cyc; end
            if (longPulse)    begin nLong++;  tLong  = cyc; end
            if (repeatPulse)  begin nRep++;   tRep.push_back(cyc); end
            if (holdActive && tHoldRise < 0) tHoldRise = cyc;
            if (!holdActive && tHoldRise >= 0 && tHoldFall < 0) tHoldFall = cyc;
            if ($countones({pressPulse, releasePulse, longPulse, repeatPulse}) > 1) multiHot++;
        end
    endtask

    task automatic doReset();
        resetN = 1'b0; btnState = 1'b0;
        step(3);
        resetN = 1'b1;
        step(2);
        clearMon();
    endtask

    task automatic test_reset();
        resetN = 1'b0; btnState = 1'b1;
        #3;
        step(4);
        nChecks++; if ({pressPulse, releasePulse, longPulse, repeatPulse, holdActive} !== 5'b0) begin
            nErrors++; $display("FAIL reset_pulses got=%b exp=00000", {pressPulse, releasePulse, longPulse, repeatPulse, holdActive});
        end
        nChecks++; if (pressCount !== 8'd0) begin
            nErrors++; $display("FAIL reset_count got=%0d exp=0", pressCount);
        end
        nChecks++; if (stateDbg !== 2'd0) begin
            nErrors++; $display("FAIL reset_state got=%0d exp=0", stateDbg);
        end
        resetN = 1'b1;
        clearMon();
        step(5);
        nChecks++; if (tPress !== 3) begin
            nErrors++; $display("FAIL reset_press_latency got=%0d exp=3", tPress);
        end
        nChecks++; if (pressCount !== 8'd1) begin
            nErrors++; $display("FAIL reset_press_count got=%0d exp=1", pressCount);
        end
        btnState = 1'b0;
        step(6);
        nChecks++; if (nRel !== 1) begin
            nErrors++; $display("FAIL reset_release_count got=%0d exp=1", nRel);
        end
    endtask

    task automatic test_short_press();
        doReset();
        btnState = 1'b1; step(5);
        btnState = 1'b0; step(6);
        nChecks++; if (nPress !== 1 || nRel !== 1) begin
            nErrors++; $display("FAIL short_counts press=%0d rel=%0d exp=1/1", nPress, nRel);
        end
        nChecks++; if (tRel - tPress !== 5) begin
            nErrors++; $display("FAIL short_width got=%0d exp=5", tRel - tPress);
        end
        nChecks++; if (nLong !== 0 || tHoldRise !== -1) begin
            nErrors++; $display("FAIL short_no_long long=%0d holdRise=%0d exp=0/-1", nLong, tHoldRise);
        end
        nChecks++; if (pressCount !== 8'd1) begin
            nErrors++; $display("FAIL short_count got=%0d exp=1", pressCount);
        end
    endtask

    task automatic test_long_hold();
        int holdLen;
`ifdef BTN_REPEAT_EN
        holdLen = 20;
`else
        holdLen = 30;
`endif
        doReset();
        btnState = 1'b1; step(holdLen);
        btnState = 1'b0; step(6);
        exp_q.delete();
`ifdef BTN_REPEAT_EN
        for (int k = LONG + REP; k < holdLen; k += REP) exp_q.push_back(32'(tPress + k));
`endif
        nChecks++; if (tLong - tPress !== LONG || nLong !== 1) begin
            nErrors++; $display("FAIL long_timing got=%0d n=%0d exp=%0d n=1", tLong - tPress, nLong, LONG);
        end
        nChecks++; if (tRel - tPress !== holdLen || nRel !== 1) begin
            nErrors++; $display("FAIL long_release got=%0d n=%0d exp=%0d n=1", tRel - tPress, nRel, holdLen);
        end
        nChecks++; if (tHoldRise !== tLong || tHoldFall !== tRel) begin
            nErrors++; $display("FAIL long_hold_window got=%0d..%0d exp=%0d..%0d", tHoldRise, tHoldFall, tLong, tRel);
        end
        nChecks++; if (tRep.size() !== exp_q.size()) begin
            nErrors++; $display("FAIL long_repeat_count got=%0d exp=%0d", tRep.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && tRep.size() > 0) begin
            nChecks++; if (32'(tRep[0]) !== exp_q[0]) begin
                nErrors++; $display("FAIL long_repeat_time got=%0d exp=%0d", tRep[0], exp_q[0]);
            end
            void'(tRep.pop_front());
            void'(exp_q.pop_front());
        end
        nChecks++; if (multiHot !== 0) begin
            nErrors++; $display("FAIL long_one_hot got=%0d exp=0", multiHot);
        end
    endtask

    task automatic test_boundary();
        // s falls exactly when the timer reaches LONG-1: release only.
        doReset();
        btnState = 1'b1; step(LONG);
        btnState = 1'b0; step(6);
        nChecks++; if (nLong !== 0 || tHoldRise !== -1) begin
            nErrors++; $display("FAIL boundary_no_long long=%0d holdRise=%0d exp=0/-1", nLong, tHoldRise);
        end
        nChecks++; if (nRel !== 1 || tRel - tPress !== LONG) begin
            nErrors++; $display("FAIL boundary_release n=%0d dt=%0d exp=1/%0d", nRel, tRel - tPress, LONG);
        end
        // One cycle longer: long press fires, then release the next cycle.
        doReset();
        btnState = 1'b1; step(LONG + 1);
        btnState = 1'b0; step(6);
        nChecks++; if (nLong !== 1 || tLong - tPress !== LONG || tRel - tLong !== 1) begin
            nErrors++; $display("FAIL boundary_plus1 long=%0d dtL=%0d dtR=%0d exp=1/%0d/1", nLong, tLong - tPress, tRel - tLong, LONG);
        end
        nChecks++; if (tHoldRise !== tLong || tHoldFall !== tRel) begin
            nErrors++; $display("FAIL boundary_plus1_hold got=%0d..%0d exp=%0d..%0d", tHoldRise, tHoldFall, tLong, tRel);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int i = 0; i < 4; i++) begin
            btnState = 1'b1; step(1);
            btnState = 1'b0; step(1);
        end
        step(6);
        nChecks++; if (nPress !== 4 || nRel !== 4) begin
            nErrors++; $display("FAIL b2b_counts press=%0d rel=%0d exp=4/4", nPress, nRel);
        end
        nChecks++; if (tPress !== 9 || tRel !== 10) begin
            nErrors++; $display("FAIL b2b_last_times press=%0d rel=%0d exp=9/10", tPress, tRel);
        end
        nChecks++; if (pressCount !== 8'd4 || multiHot !== 0) begin
            nErrors++; $display("FAIL b2b_count got=%0d multi=%0d exp=4/0", pressCount, multiHot);
        end
    endtask

    task automatic test_wrap_and_reset();
        int relBefore;
        int pressBefore;
        doReset();
        for (int i = 0; i < 256; i++) begin
            btnState = 1'b1; step(3);
            if (i == 0 || i == 254 || i == 255) begin
                nChecks++; if (pressCount !== 8'((i + 1) % 256)) begin
                    nErrors++; $display("FAIL wrap_count_%0d got=%0d exp=%0d", i, pressCount, (i + 1) % 256);
                end
            end
            btnState = 1'b0; step(3);
        end
        step(6);
        nChecks++; if (nPress !== 256 || nRel !== 256 || pressCount !== 8'd0) begin
            nErrors++; $display("FAIL wrap_totals press=%0d rel=%0d count=%0d exp=256/256/0", nPress, nRel, pressCount);
        end
        btnState = 1'b1; step(LONG + 6);
        nChecks++; if (holdActive !== 1'b1) begin
            nErrors++; $display("FAIL midhold_entered got=%b exp=1", holdActive);
        end
        relBefore = nRel;
        pressBefore = nPress;
        #2;
        resetN = 1'b0;
        #1;
        nChecks++; if (holdActive !== 1'b0 || stateDbg !== 2'd0 || pressCount !== 8'd0) begin
            nErrors++; $display("FAIL midhold_async hold=%b state=%0d count=%0d exp=0/0/0", holdActive, stateDbg, pressCount);
        end
        step(4);
        btnState = 1'b0;
        resetN = 1'b1;
        step(6);
        nChecks++; if (nRel !== relBefore || nPress !== pressBefore) begin
            nErrors++; $display("FAIL midhold_no_release rel=%0d press=%0d exp=%0d/%0d", nRel, nPress, relBefore, pressBefore);
        end
    endtask

    initial begin
        resetN = 1'b0;
        btnState = 1'b0;
        clearMon();
        test_reset();
        test_short_press();
        test_long_hold();
        test_boundary();
        test_back_to_back();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
